flash_boot_copier: RTL

//   AXI4 read master that copies a block of words from the quad-SPI flash XIP window into local SRAM.

---
 rtl/flash_boot_copier_if.sv | 36 +++
 rtl/flash_boot_copier.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/flash_boot_copier_if.sv
// AXI4 read-address / read-data channel bundle between the boot copier
// (master) and the quad-SPI XIP slave.
//   AR: arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
//       arvalid (master -> slave), arready (slave -> master)
//   R : rid, rdata, rresp, rlast, rvalid (slave -> master), rready (master -> slave)
interface flash_boot_copier_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 1
);
  logic [ID_WIDTH-1:0]   arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arlock;
  logic [3:0]            arcache;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [ID_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );
  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/flash_boot_copier.sv
// Copies num_words words from the flash XIP window into local SRAM using
// INCR bursts, one AR outstanding at a time.
//   axi_clk, axi_aresetn        : clock, async active-low reset
//   start, src_addr, dst_addr,
//   num_words                   : copy request (sampled only in IDLE)
//   busy, done, error           : status (done is a 1-cycle pulse, error sticky)
//   m_axi                       : AXI4 read master (AR + R channels)
//   mem_wen, mem_waddr, mem_wdata : SRAM write port, one full word per beat
module flash_boot_copier #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int ID_WIDTH       = 1,
  parameter int MAX_BURST      = 16,
  parameter int LEN_WIDTH      = 16,
  parameter int MEM_ADDR_WIDTH = 14
) (
  input  logic                      axi_clk,
  input  logic                      axi_aresetn,
  input  logic                      start,
  input  logic [ADDR_WIDTH-1:0]     src_addr,
  input  logic [MEM_ADDR_WIDTH-1:0] dst_addr,
  input  logic [LEN_WIDTH-1:0]      num_words,
  output logic                      busy,
  output logic                      done,
  output logic                      error,
  flash_boot_copier_if.master       m_axi,
  output logic                      mem_wen,
  output logic [MEM_ADDR_WIDTH-1:0] mem_waddr,
  output logic [DATA_WIDTH-1:0]     mem_wdata
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int BSH   = $clog2(BYTES);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, FINISH} state_t;
  state_t state;

  logic [ADDR_WIDTH-1:0]     cur_addr;
  logic [MEM_ADDR_WIDTH-1:0] cur_dst;
  logic [LEN_WIDTH-1:0]      remaining;
  logic [8:0]                beats;
  logic [7:0]                beat_cnt;
  logic                      arvalid_q;
  logic [ADDR_WIDTH-1:0]     araddr_q;
  logic [7:0]                arlen_q;
  logic                      rready_q;

  assign m_axi.arid    = '0;
  assign m_axi.araddr  = araddr_q;
  assign m_axi.arlen   = arlen_q;
  assign m_axi.arsize  = 3'(BSH);
  assign m_axi.arburst = 2'b01;
  assign m_axi.arlock  = 1'b0;
  assign m_axi.arcache = 4'b0011;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.rready  = rready_q;

  // Burst size: never past the remaining count, MAX_BURST, or the next 4 KB page.
  logic [12:0] words_to_4k;
  logic [31:0] beats_w;
  assign words_to_4k = (13'h1000 - {1'b0, cur_addr[11:0]}) >> BSH;

  always_comb begin
    beats_w = 32'(MAX_BURST);
    if (32'(words_to_4k) < beats_w) beats_w = 32'(words_to_4k);
    if (32'(remaining) < beats_w)   beats_w = 32'(remaining);
  end

  logic beat, last_beat, beat_err, rlast_err;
  assign beat      = m_axi.rvalid & rready_q;
  assign last_beat = (beat_cnt == arlen_q);
  assign beat_err  = (m_axi.rresp != 2'b00);
  assign rlast_err = (m_axi.rlast != last_beat);

  always_ff @(posedge axi_clk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state     <= IDLE;
      cur_addr  <= '0;
      cur_dst   <= '0;
      remaining <= '0;
      beats     <= '0;
      beat_cnt  <= '0;
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      rready_q  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      mem_wen   <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= '0;
    end else begin
      done    <= 1'b0;
      mem_wen <= 1'b0;
      case (state)
        IDLE: if (start) begin
          cur_addr  <= src_addr & ~ADDR_WIDTH'(BYTES - 1);
          cur_dst   <= dst_addr;
          remaining <= num_words;
          error     <= 1'b0;
          busy      <= 1'b1;
          state     <= (num_words == '0) ? FINISH : ADDR;
        end
        // First ADDR cycle loads the payload; it then holds until arready.
        ADDR: if (!arvalid_q) begin
          arvalid_q <= 1'b1;
          araddr_q  <= cur_addr;
          arlen_q   <= 8'(beats_w - 32'd1);
          beats     <= 9'(beats_w);
        end else if (m_axi.arready) begin
          arvalid_q <= 1'b0;
          rready_q  <= 1'b1;
          beat_cnt  <= '0;
          state     <= DATA;
        end
        DATA: if (beat) begin
          // Once an error is seen the rest of the burst is drained, not written.
          if (!beat_err && !error) begin
            mem_wen   <= 1'b1;
            mem_waddr <= cur_dst;
            mem_wdata <= m_axi.rdata;
            cur_dst   <= cur_dst + MEM_ADDR_WIDTH'(1);
          end
          if (beat_err || rlast_err) error <= 1'b1;
          beat_cnt <= beat_cnt + 8'd1;
          if (last_beat) begin
            rready_q  <= 1'b0;
            cur_addr  <= cur_addr + (ADDR_WIDTH'(beats) << BSH);
            remaining <= remaining - LEN_WIDTH'(beats);
            state     <= (remaining == LEN_WIDTH'(beats) || error || beat_err || rlast_err)
                         ? FINISH : ADDR;
          end
        end
        FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
